// File: rtl/uart_pkg.sv
// Shared constants and divisor type for the UART baud-rate generator and its
// register-block interface.
package uart_pkg;

  localparam int unsigned DIV_INT_WIDTH   = 16;
  localparam int unsigned DIV_FRAC_WIDTH  = 4;
  localparam int unsigned OVERSAMPLE_RATE = 16;
  localparam int unsigned RESET_DIV_INT   = 27;
  localparam int unsigned RESET_DIV_FRAC  = 2;

  typedef struct packed {
    logic [DIV_INT_WIDTH-1:0]  whole;
    logic [DIV_FRAC_WIDTH-1:0] frac;
  } baud_div_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Divisor programming bus between the register block (master) and the
// baud-rate generator (slave).
interface uart_baud_gen_if;
  import uart_pkg::*;

  logic [DIV_INT_WIDTH-1:0]  div_int;
  logic [DIV_FRAC_WIDTH-1:0] div_frac;
  logic                      div_load;
  logic                      div_pending;
  logic                      div_err;

  modport master (
    output div_int, div_frac, div_load,
    input  div_pending, div_err
  );

  modport slave (
    input  div_int, div_frac, div_load,
    output div_pending, div_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: 16x sample_tick and 1x bit_tick from an
// int.frac divisor; new divisors are applied only on a tick boundary.
module uart_baud_gen #(
  parameter int unsigned OVERSAMPLE_RATE = uart_pkg::OVERSAMPLE_RATE,
  parameter int unsigned RESET_DIV_INT   = uart_pkg::RESET_DIV_INT,
  parameter int unsigned RESET_DIV_FRAC  = uart_pkg::RESET_DIV_FRAC
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  uart_baud_gen_if.slave        div_bus,
  output logic                  sample_tick,
  output logic                  bit_tick
);
  import uart_pkg::*;

  localparam int unsigned OS_W = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;

  baud_div_t                 act_div;
  baud_div_t                 pend_div;
  logic                      pend_valid;
  logic                      err_q;
  logic [DIV_INT_WIDTH-1:0]  cnt;
  logic [DIV_FRAC_WIDTH-1:0] frac_acc;
  logic [OS_W-1:0]           os_cnt;

  logic                      load_ok;
  logic                      load_bad;
  logic                      apply_now;
  logic                      os_wrap;
  logic [DIV_FRAC_WIDTH:0]   frac_sum;
  logic [DIV_INT_WIDTH-1:0]  carry_ext;

  always_comb begin
    load_ok     = div_bus.div_load && (div_bus.div_int >= DIV_INT_WIDTH'(2));
    load_bad    = div_bus.div_load && !load_ok;
    sample_tick = enable && (cnt == '0);
    os_wrap     = (os_cnt == OS_W'(OVERSAMPLE_RATE - 1));
    bit_tick    = sample_tick && os_wrap;
    // A load landing on the apply edge supersedes the old pending value and
    // waits for the next boundary instead of being applied now.
    apply_now   = pend_valid && !load_ok && (!enable || sample_tick);
    frac_sum    = {1'b0, frac_acc} + {1'b0, act_div.frac};
    carry_ext   = DIV_INT_WIDTH'(frac_sum[DIV_FRAC_WIDTH]);
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_div.whole <= DIV_INT_WIDTH'(RESET_DIV_INT);
      act_div.frac  <= DIV_FRAC_WIDTH'(RESET_DIV_FRAC);
      pend_div      <= '0;
      pend_valid    <= 1'b0;
      err_q         <= 1'b0;
      cnt           <= '0;
      frac_acc      <= '0;
      os_cnt        <= '0;
    end else begin
      if (load_ok) begin
        pend_div.whole <= div_bus.div_int;
        pend_div.frac  <= div_bus.div_frac;
        pend_valid     <= 1'b1;
        err_q          <= 1'b0;
      end else if (load_bad) begin
        err_q <= 1'b1;
      end

      if (apply_now) begin
        act_div    <= pend_div;
        pend_valid <= 1'b0;
      end

      if (!enable) begin
        cnt      <= (apply_now ? pend_div.whole : act_div.whole) - DIV_INT_WIDTH'(1);
        frac_acc <= '0;
        os_cnt   <= '0;
      end else if (sample_tick) begin
        os_cnt <= os_wrap ? '0 : os_cnt + OS_W'(1);
        if (apply_now) begin
          cnt      <= pend_div.whole - DIV_INT_WIDTH'(1);
          frac_acc <= '0;
        end else begin
          cnt      <= act_div.whole - DIV_INT_WIDTH'(1) + carry_ext;
          frac_acc <= frac_sum[DIV_FRAC_WIDTH-1:0];
        end
      end else begin
        cnt <= cnt - DIV_INT_WIDTH'(1);
      end
    end
  end

  assign div_bus.div_pending = pend_valid;
  assign div_bus.div_err     = err_q;

endmodule
